// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 buffered demultiplexer.
// The DEMUX_CNT_EN macro controls the per-port transfer counters.
package demux_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Pointers are 1 bit wide, so stepping past the last slot wraps back to slot 0.
    function automatic logic ptr_inc(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/demux_out_buf.sv
// One 2-entry output buffer: a push/full side and a valid/data/ready side.
// When DEMUX_CNT_EN is defined, the out_cnt output counts completed pops.
module demux_out_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] out_cnt
`endif
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q;
    assign do_push   = push && !full;
    assign do_pop    = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // The head is registered so the output keeps its last value once the buffer drains.
        if (count_d != 2'd0) begin
            data_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            data_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`endif

endmodule

// File: rtl/demux1to2_buf.sv
// 1-to-2 valid/ready demultiplexer with an independent 2-entry buffer per output.
// Defining DEMUX_CNT_EN adds the A_cnt/B_cnt completed-transfer counters.
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             A_valid,
    output logic [WIDTH-1:0] A_data,
    input  logic             A_ready,
    output logic             B_valid,
    output logic [WIDTH-1:0] B_data,
    input  logic             B_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] A_cnt,
    output logic [CNT_W-1:0] B_cnt
`endif
);

    logic a_full, b_full;
    logic push_a, push_b;

    // Readiness follows only the selected buffer's occupancy; there is no pass-through.
    assign in_ready = (Sel == PORT_B) ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && (Sel == PORT_A);
    assign push_b   = in_valid && in_ready && (Sel == PORT_B);

    demux_out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .full      (a_full),
        .out_valid (A_valid),
        .out_data  (A_data),
        .out_ready (A_ready)
`ifdef DEMUX_CNT_EN
        ,
        .out_cnt   (A_cnt)
`endif
    );

    demux_out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .full      (b_full),
        .out_valid (B_valid),
        .out_data  (B_data),
        .out_ready (B_ready)
`ifdef DEMUX_CNT_EN
        ,
        .out_cnt   (B_cnt)
`endif
    );

endmodule

// File: tb/tb_demux1to2_buf.sv
// Scoreboard bench for demux1to2_buf: per-port reference queues, decoupled monitor.
module tb_demux1to2_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       A_valid, B_valid;
    logic [7:0] A_data, B_data;
    logic       A_ready = 1'b0;
    logic       B_ready = 1'b0;
`ifdef DEMUX_CNT_EN
    logic [15:0] A_cnt, B_cnt;
`endif

    demux1to2_buf #(.WIDTH(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Sel      (Sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .A_valid  (A_valid),
        .A_data   (A_data),
        .A_ready  (A_ready),
        .B_valid  (B_valid),
        .B_data   (B_data),
        .B_ready  (B_ready)
`ifdef DEMUX_CNT_EN
        ,
        .A_cnt    (A_cnt),
        .B_cnt    (B_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each port still owes, in acceptance order.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    int         pops_a = 0;
    int         pops_b = 0;
    int         accepted = 0;
    logic       stall_a = 1'b0;
    logic       stall_b = 1'b0;
    logic [7:0] stall_a_data = 8'h00;
    logic [7:0] stall_b_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Acceptance recorder: inputs are stable at the falling edge, transfer happens on the next rise.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            if (Sel == 1'b0) qa.push_back(in_data);
            else             qb.push_back(in_data);
            accepted++;
        end
    end

    // Monitor: compares what the DUT presents after each edge with the reference queues.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (Sel ? (qb.size() < 2) : (qa.size() < 2))});

            chk("A_valid", {31'd0, A_valid}, {31'd0, qa.size() != 0});
            if (qa.size() != 0) chk("A_data", {24'd0, A_data}, {24'd0, qa[0]});
            else                chk("A_data_hold", {24'd0, A_data}, {24'd0, last_a});
            if (stall_a) chk("A_stable", {23'd0, A_valid, A_data}, {23'd0, 1'b1, stall_a_data});

            chk("B_valid", {31'd0, B_valid}, {31'd0, qb.size() != 0});
            if (qb.size() != 0) chk("B_data", {24'd0, B_data}, {24'd0, qb[0]});
            else                chk("B_data_hold", {24'd0, B_data}, {24'd0, last_b});
            if (stall_b) chk("B_stable", {23'd0, B_valid, B_data}, {23'd0, 1'b1, stall_b_data});

`ifdef DEMUX_CNT_EN
            chk("A_cnt", {16'd0, A_cnt}, {16'd0, 16'(pops_a)});
            chk("B_cnt", {16'd0, B_cnt}, {16'd0, 16'(pops_b)});
            chk("cnt_sum", 32'(A_cnt) + 32'(B_cnt), 32'(accepted - qa.size() - qb.size()));
`endif

            stall_a = (qa.size() != 0) && !A_ready;
            stall_b = (qb.size() != 0) && !B_ready;
            if (stall_a) stall_a_data = qa[0];
            if (stall_b) stall_b_data = qb[0];
            if (qa.size() != 0 && A_ready) begin
                last_a = qa.pop_front();
                pops_a++;
            end
            if (qb.size() != 0 && B_ready) begin
                last_b = qb.pop_front();
                pops_b++;
            end
        end
    end

    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic ar, input logic br);
        @(posedge clk);
        #1;
        in_valid = v;
        Sel      = s;
        in_data  = d;
        A_ready  = ar;
        B_ready  = br;
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        last_a   = 8'h00;
        last_b   = 8'h00;
        pops_a   = 0;
        pops_b   = 0;
        accepted = 0;
        stall_a  = 1'b0;
        stall_b  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset, then release away from the clock edge.
        #1;
        chk("rst_A_valid", {31'd0, A_valid}, 32'd0);
        chk("rst_B_valid", {31'd0, B_valid}, 32'd0);
        chk("rst_A_data", {24'd0, A_data}, 32'd0);
        chk("rst_B_data", {24'd0, B_data}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Routing: one word to each port, both consumers ready.
        step(1, 0, 8'h3C, 1, 1);
        step(1, 1, 8'hA5, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Backpressure on A while B keeps accepting; 8'h03 waits at the input.
        step(1, 0, 8'h01, 0, 1);
        step(1, 0, 8'h02, 0, 1);
        step(1, 0, 8'h03, 0, 1);
        step(1, 1, 8'h77, 0, 1);
        step(1, 0, 8'h03, 0, 1);
        step(1, 0, 8'h03, 0, 1);
        #2 chk("full_in_ready", {31'd0, in_ready}, 32'd0);

        // Drain A in order, with 8'h03 entering once space opens.
        step(1, 0, 8'h03, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        repeat (4) step(0, 0, 8'h00, 1, 1);

        // Simultaneous push and pop at occupancy 1.
        step(1, 0, 8'h10, 0, 0);
        step(1, 0, 8'h11, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        #2 chk("pushpop_A_data", {24'd0, A_data}, 32'h11);
        chk("pushpop_A_valid", {31'd0, A_valid}, 32'd1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with entries buffered in both ports.
        step(1, 0, 8'h5A, 0, 0);
        step(1, 1, 8'hC3, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_A_valid", {31'd0, A_valid}, 32'd0);
        chk("async_B_valid", {31'd0, B_valid}, 32'd0);
        chk("async_A_data", {24'd0, A_data}, 32'd0);
        chk("async_B_data", {24'd0, B_data}, 32'd0);
        clear_model();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Short run after reset, then drain everything.
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (6) step(0, 0, 8'h00, 1, 1);
        #3;
        chk("final_qa_empty", 32'(qa.size()), 32'd0);
        chk("final_qb_empty", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux1to2_buf.md
Name: demux1to2_buf

Overview:
- Sequential counterpart of the 2-to-1 mux: a 1-to-2 demultiplexer that routes a valid/ready input stream to output port A or port B, selected per transfer by Sel.
- Each output has its own 2-entry buffer, so a stalled output does not block traffic to the other port.
- Sits between a single producer and two consumers in the lab datapath.

Parameters:
- WIDTH, 8, data bit width on all ports.
- DEPTH, 2, entries per output buffer; fixed at 2, other values not supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Sel  input  1  route select, sampled with the input transfer: 0 -> port A, 1 -> port B.
- in_valid  input  1  producer has data.
- in_data  input  WIDTH  input payload.
- in_ready  output  1  block accepts the current transfer.
- A_valid  output  1  port A head entry valid.
- A_data  output  WIDTH  port A head payload.
- A_ready  input  1  port A consumer accepts.
- B_valid  output  1  port B head entry valid.
- B_data  output  WIDTH  port B head payload.
- B_ready  input  1  port B consumer accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: both buffers empty (count 0), A_valid = B_valid = 0, A_data = B_data = 0, read/write pointers 0.
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- in_ready: combinational. Equals (count_A < 2) when Sel = 0, and (count_B < 2) when Sel = 1.
- in_ready never depends on in_valid or on the output ready signals. There is no pass-through when a buffer is full.
- Input transfer: in_valid && in_ready at a rising clk edge. in_data is written into the buffer chosen by Sel.
- The non-selected buffer is never written.
- Output transfer: X_valid && X_ready at a rising clk edge (X = A or B). The head entry is popped and the read pointer advances, wrapping 1 -> 0.
- Latency: one cycle. Data accepted at edge n appears on X_data with X_valid = 1 after edge n.
- Ordering: each port delivers its data in acceptance order. There is no ordering relation between ports A and B.
- Output stability: while X_valid = 1 and X_ready = 0, X_data and X_valid hold constant.
- X_valid = (count_X != 0). X_data = the head entry. When the buffer is empty, X_data holds its last value (0 after reset).
- Simultaneous push and pop on the same buffer: count is unchanged and both pointers advance.
  - At count 1: the new head is the pushed data.
  - At count 2: cannot occur, because in_ready = 0 when full.
- Push to a full buffer: blocked by in_ready = 0, and the input holds.
- Pop from an empty buffer: ignored, since X_valid = 0.
- Sel may change every cycle. Sel is only meaningful while in_valid = 1.
- Pointer width: 1 bit each. Count width: 2 bits, range 0..2.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- When defined, the block adds two 16-bit outputs, A_cnt and B_cnt.
  - Each counts completed output transfers on its port.
  - Reset to 0; wrap from 16'hFFFF to 0.
  - Each updates in the same edge as the pop.
- When not defined: no counters, no extra ports, and the remaining behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - localparam BUF_DEPTH = 2.
  - localparam CNT_W = 16.
  - Port-index constants PORT_A = 1'b0 and PORT_B = 1'b1.
- Sub-module demux_out_buf: one 2-entry buffer with a push/full interface on one side and a valid/data/ready interface on the other.
  - Instantiated twice.
  - Includes the optional counter under DEMUX_CNT_EN.
- The top level holds only the Sel decode, the in_ready mux, and the two instances.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with 1 entry in A -> A_valid = B_valid = 0 and A_data = 0 immediately, without waiting for clk; in_ready = 1 after release.
- Routing: Sel = 0, in_data = 8'h3C, then Sel = 1, in_data = 8'hA5, with A_ready = B_ready = 1 -> A_data = 8'h3C one cycle after acceptance, B_data = 8'hA5 one cycle later; A_valid and B_valid each high for exactly 1 cycle.
- Full/backpressure: A_ready = 0, push 8'h01, 8'h02, 8'h03 to A -> in_ready = 0 after the second push; 8'h03 is held at the input; B still accepts 8'h77 in the same cycle with Sel = 1.
- Drain order: release A_ready -> A_data sequence 8'h01, 8'h02, 8'h03 on consecutive cycles, with no loss or duplication.
- Simultaneous push/pop: count_A = 1 (8'h10), push 8'h11 while popping -> next cycle A_data = 8'h11, A_valid = 1, count 1.
- Stability/random: random Sel, in_valid, A_ready and B_ready for 1000 cycles against a per-port reference queue -> all data matches, and data is stable under stall. With DEMUX_CNT_EN, A_cnt + B_cnt equals the number of accepted transfers minus the buffered count.
